debounce_multi: RTL and testbench

- Multi-channel synchronous debouncer. Successor to the single-channel button filter.
- Per channel it provides:
  - a configurable synchronizer chain,
  - a run-time-programmable stability threshold,
  - input polarity selection,
  - one-cycle press/release pulses,
  - a long-press flag.
- Sits between raw FPGA pins (buttons, switches, slow strobes) and user logic. All outputs are synchronous to clk.

---
 rtl/debounce_multi.sv | 55 +++++
 tb/tb_debounce_multi.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchronizer and stability-count debouncer
// with registered press/release pulses and a saturating long-press flag.
module debounce_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int LONG_WIDTH  = 24,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  din,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [CHANNELS-1:0]  dout,
    output logic [CHANNELS-1:0]  rise,
    output logic [CHANNELS-1:0]  fall,
    output logic [CHANNELS-1:0]  long_press
);
    localparam logic IDLE = (ACTIVE_LOW != 0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [CNT_WIDTH-1:0]   cnt;
        logic [LONG_WIDTH-1:0]  hold;
        logic                   d, r, f, l;
        logic                   s, accept, d_nxt;
        assign s      = sync[SYNC_STAGES-1] ^ IDLE;
        assign accept = (s != d) && (cnt >= limit);
        assign d_nxt  = accept ? s : d;
        // long_press follows the next dout so it drops on the same edge as the release
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= {SYNC_STAGES{IDLE}};
                cnt  <= '0;
                hold <= '0;
                d    <= 1'b0;
                r    <= 1'b0;
                f    <= 1'b0;
                l    <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], din[i]};
                cnt  <= (s == d || accept) ? '0 : cnt + 1'b1;
                hold <= !d ? '0 : (&hold ? hold : hold + 1'b1);
                d    <= d_nxt;
                r    <= accept && s;
                f    <= accept && !s;
                l    <= d_nxt && (&hold);
            end
        end
        assign dout[i]       = d;
        assign rise[i]       = r;
        assign fall[i]       = f;
        assign long_press[i] = l;
    end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: scoreboard bench; stimulus queues hand-computed output
// changes (cycle + full output vector), a negedge monitor pops on every change.
module tb_debounce_multi;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  din, din_al;
    logic [15:0] limit, limit_al;
    logic [3:0]  dout, rise, fall, lp;
    logic [3:0]  al_dout, al_rise, al_fall, al_lp;
    logic [31:0] cur, prev = '0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          k;

    typedef struct {int c; logic [31:0] v;} ev_t;
    ev_t q[$];

    debounce_multi #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_WIDTH(16), .LONG_WIDTH(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .limit(limit),
        .dout(dout), .rise(rise), .fall(fall), .long_press(lp)
    );

    debounce_multi #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_WIDTH(16), .LONG_WIDTH(4), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .din(din_al), .limit(limit_al),
        .dout(al_dout), .rise(al_rise), .fall(al_fall), .long_press(al_lp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur = {al_lp, al_fall, al_rise, al_dout, lp, fall, rise, dout};

    function automatic logic [15:0] v(input logic [3:0] d, r, f, l);
        return {l, f, r, d};
    endfunction

    task automatic put(input int c, input logic [15:0] a, input logic [15:0] m);
        ev_t e;
        e.c = c;
        e.v = {a, m};
        q.push_back(e);
    endtask

    task automatic till(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cur !== prev) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: cycle %0d got %h, no change expected", cyc, cur);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.c != cyc || e.v !== cur) begin
                    fails++;
                    $display("FAIL event: got cycle %0d vec %h expected cycle %0d vec %h", cyc, cur, e.c, e.v);
                end
            end
            prev = cur;
        end
    end

    initial begin
        rst_n = 1'b0; din = 4'h0; din_al = 4'hF; limit = 16'd3; limit_al = 16'd0;
        till(2);
        chk("reset_main", cur[15:0], 32'h0);
        chk("reset_al", cur[31:16], 32'h0);
        till(3);
        rst_n = 1'b1;
        // active-low instance, limit 0: 2 sync + 1 cycle, no pulse at reset release
        till(6); k = cyc;
        din_al[3] = 1'b0;
        put(k + 3, v(8, 8, 0, 0), 0);
        put(k + 4, v(8, 0, 0, 0), 0);
        till(k + 8);
        din_al[3] = 1'b1;
        put(k + 11, v(0, 0, 8, 0), 0);
        put(k + 12, 0, 0);
        // clean press on ch0, released before long press
        till(30);
        din[0] = 1'b1;
        put(36, 0, v(1, 1, 0, 0));
        put(37, 0, v(1, 0, 0, 0));
        till(40);
        din[0] = 1'b0;
        put(46, 0, v(0, 0, 1, 0));
        put(47, 0, 0);
        // bounce on ch1: 1,0,1,0 every 2 cycles then held
        till(60);
        din[1] = 1'b1; till(62);
        din[1] = 1'b0; till(64);
        din[1] = 1'b1; till(66);
        din[1] = 1'b0; till(68);
        din[1] = 1'b1;
        put(74, 0, v(2, 2, 0, 0));
        put(75, 0, v(2, 0, 0, 0));
        till(80);
        din[1] = 1'b0;
        put(86, 0, v(0, 0, 2, 0));
        put(87, 0, 0);
        // long press on ch2
        till(100);
        din[2] = 1'b1;
        put(106, 0, v(4, 4, 0, 0));
        put(107, 0, v(4, 0, 0, 0));
        put(122, 0, v(4, 0, 0, 4));
        till(146);
        din[2] = 1'b0;
        put(152, 0, v(0, 0, 4, 0));
        put(153, 0, 0);
        // limit lowered from 10 to 5 with cnt at 7 on ch3
        till(170);
        limit = 16'd10;
        din[3] = 1'b1;
        put(180, 0, v(8, 8, 0, 0));
        put(181, 0, v(8, 0, 0, 0));
        till(179);
        limit = 16'd5;
        till(184);
        din[3] = 1'b0;
        put(192, 0, v(0, 0, 8, 0));
        put(193, 0, 0);
        till(200);
        limit = 16'd3;
        // all channels pressed to long press, then async reset between edges
        till(220);
        din = 4'hF;
        put(226, 0, v(4'hF, 4'hF, 0, 0));
        put(227, 0, v(4'hF, 0, 0, 0));
        put(242, 0, v(4'hF, 0, 0, 4'hF));
        till(250);
        put(251, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_dout", {28'h0, dout}, 32'h0);
        chk("async_rise", {28'h0, rise}, 32'h0);
        chk("async_fall", {28'h0, fall}, 32'h0);
        chk("async_long", {28'h0, lp}, 32'h0);
        till(253);
        rst_n = 1'b1;
        put(259, 0, v(4'hF, 4'hF, 0, 0));
        put(260, 0, v(4'hF, 0, 0, 0));
        put(275, 0, v(4'hF, 0, 0, 4'hF));
        till(285);
        chk("events_pending", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
